// File: rtl/l2_cache_pkg.sv
// Common types for the L2 cache: line-address and line-data widths, plus
// the per-field write enables of the line array.
package l2_cache_pkg;
`include "cache.svh"

   localparam int LA          = `ADDR_BITS - `OFFSET_BITS;
   localparam int LINE_W      = `CACHELINE_BITS;
   localparam int L2_SETS_DEF = `L2_SETS;

   typedef logic [LA-1:0]     laddr_t;
   typedef logic [LINE_W-1:0] line_t;

   typedef struct packed {
      logic valid_we;
      logic dirty_we;
      logic tag_we;
      logic data_we;
   } arr_we_t;
endpackage

// File: rtl/cache.svh
// Shared cache geometry macros. Each one can be overridden on the command line.
`ifndef CACHE_SVH
`define CACHE_SVH

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif

`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif

`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

`ifndef L2_SETS
`define L2_SETS 256
`endif

`endif

// File: rtl/l2_array.sv
// Line storage for the direct-mapped L2: combinational read by index,
// synchronous write with per-field enables, and valid/dirty cleared by reset.
module l2_array
   import l2_cache_pkg::*;
#(
   parameter int SETS = 256
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [$clog2(SETS)-1:0]        rd_idx_i,
   output logic                           rd_valid_o,
   output logic                           rd_dirty_o,
   output logic [LA-$clog2(SETS)-1:0]     rd_tag_o,
   output line_t                          rd_data_o,
   input  logic [$clog2(SETS)-1:0]        wr_idx_i,
   input  arr_we_t                        wr_we_i,
   input  logic                           wr_valid_i,
   input  logic                           wr_dirty_i,
   input  logic [LA-$clog2(SETS)-1:0]     wr_tag_i,
   input  line_t                          wr_data_i
);
   localparam int TAG = LA - $clog2(SETS);

   logic [SETS-1:0] valid_q;
   logic [SETS-1:0] dirty_q;
   logic [TAG-1:0]  tag_q  [SETS];
   line_t           data_q [SETS];

   // Only the state bits are reset; tag and data are qualified by valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (wr_we_i.valid_we) valid_q[wr_idx_i] <= wr_valid_i;
         if (wr_we_i.dirty_we) dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_we_i.tag_we)  tag_q[wr_idx_i]  <= wr_tag_i;
      if (wr_we_i.data_we) data_q[wr_idx_i] <= wr_data_i;
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back, write-allocate L2 below the coherence bus; one
// request in flight, misses and dirty victims go to the backing memory.
module l2_cache
   import l2_cache_pkg::*;
#(
   parameter int SETS = L2_SETS_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        l2_req_valid_i,
   output logic        l2_req_ready_o,
   input  laddr_t      l2_req_addr_i,
   input  logic        l2_req_rw_i,
   input  line_t       l2_req_data_i,
   output logic        l2_resp_valid_o,
   output line_t       l2_resp_data_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output laddr_t      mem_req_addr_o,
   output logic        mem_req_rw_o,
   output line_t       mem_req_data_o,
   input  logic        mem_resp_valid_i,
   input  line_t       mem_resp_data_i,
   output logic [2:0]  dbg_state_o
);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = LA - IDX;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_RESP
   } state_e;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; a valid request holds all its fields until then.
   state_e         state_q, state_d;
   laddr_t         addr_q;
   logic           rw_q;
   line_t          data_q;
   line_t          fill_q, fill_d;

   logic [IDX-1:0] req_idx;
   logic [TAG-1:0] req_tag;
   logic           rd_valid, rd_dirty, hit;
   logic [TAG-1:0] rd_tag;
   line_t          rd_data;
   arr_we_t        wr_we;
   logic           wr_valid, wr_dirty;
   line_t          wr_data;

   assign req_idx     = addr_q[IDX-1:0];
   assign req_tag     = addr_q[LA-1:IDX];
   assign hit         = rd_valid && (rd_tag == req_tag);
   assign dbg_state_o = state_q;

   l2_array #(.SETS(SETS)) u_array (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_idx_i   (req_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_idx_i   (req_idx),
      .wr_we_i    (wr_we),
      .wr_valid_i (wr_valid),
      .wr_dirty_i (wr_dirty),
      .wr_tag_i   (req_tag),
      .wr_data_i  (wr_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         data_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         if (state_q == S_IDLE && l2_req_valid_i) begin
            addr_q <= l2_req_addr_i;
            rw_q   <= l2_req_rw_i;
            data_q <= l2_req_data_i;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      fill_d          = fill_q;
      wr_we           = '0;
      wr_valid        = 1'b0;
      wr_dirty        = 1'b0;
      wr_data         = data_q;
      l2_req_ready_o  = 1'b0;
      l2_resp_valid_o = 1'b0;
      l2_resp_data_o  = '0;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      mem_req_rw_o    = 1'b0;
      mem_req_data_o  = '0;
      unique case (state_q)
         S_IDLE: begin
            l2_req_ready_o = 1'b1;
            if (l2_req_valid_i) state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (hit) begin
               if (rw_q) begin
                  wr_we.data_we  = 1'b1;
                  wr_we.dirty_we = 1'b1;
                  wr_dirty       = 1'b1;
               end else begin
                  l2_resp_valid_o = 1'b1;
                  l2_resp_data_o  = rd_data;
               end
               state_d = S_IDLE;
            end else if (rd_valid && rd_dirty) begin
               state_d = S_WB_REQ;
            end else if (rw_q) begin
               wr_we    = '1;
               wr_valid = 1'b1;
               wr_dirty = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_FILL_REQ;
            end
         end
         S_WB_REQ: begin
            // Victim is still readable at req_idx until the new line lands.
            mem_req_valid_o = 1'b1;
            mem_req_rw_o    = 1'b1;
            mem_req_addr_o  = {rd_tag, req_idx};
            mem_req_data_o  = rd_data;
            if (mem_req_ready_i) begin
               if (rw_q) begin
                  wr_we    = '1;
                  wr_valid = 1'b1;
                  wr_dirty = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  state_d = S_FILL_REQ;
               end
            end
         end
         S_FILL_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = addr_q;
            if (mem_req_ready_i) state_d = S_FILL_WAIT;
         end
         S_FILL_WAIT: begin
            if (mem_resp_valid_i) begin
               wr_we    = '1;
               wr_valid = 1'b1;
               wr_data  = mem_resp_data_i;
               fill_d   = mem_resp_data_i;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            l2_resp_valid_o = 1'b1;
            l2_resp_data_o  = fill_q;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: bus driver tasks, a 3-cycle backing-memory model that
// scores memory requests against an expected queue, and per-scenario tests.
module tb_l2_cache;
   import l2_cache_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       l2_req_valid = 1'b0;
   logic       l2_req_ready;
   laddr_t     l2_req_addr = '0;
   logic       l2_req_rw = 1'b0;
   line_t      l2_req_data = '0;
   logic       l2_resp_valid;
   line_t      l2_resp_data;
   logic       mem_req_valid;
   logic       mem_req_ready = 1'b1;
   laddr_t     mem_req_addr;
   logic       mem_req_rw;
   line_t      mem_req_data;
   logic       mem_resp_valid = 1'b0;
   line_t      mem_resp_data = '0;
   logic [2:0] dbg_state;

   typedef struct {
      logic   rw;
      laddr_t addr;
      line_t  data;
   } mreq_t;

   logic [LINE_W-1:0] exp_q[$];
   mreq_t             exp_mem_q[$];
   line_t             mem_store [laddr_t];

   int n_checks = 0, n_pass = 0;
   int cyc = 0, hs_cyc = 0, first_req_cyc = -1, mresp_cyc = -1;
   int mem_idle_err = 0, resp_idle_err = 0;

   localparam line_t LINE_A5 = {64{8'hA5}};
   localparam line_t LINE_DB = {16{32'hDEADBEEF}};

   l2_cache dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .l2_req_valid_i   (l2_req_valid),
      .l2_req_ready_o   (l2_req_ready),
      .l2_req_addr_i    (l2_req_addr),
      .l2_req_rw_i      (l2_req_rw),
      .l2_req_data_i    (l2_req_data),
      .l2_resp_valid_o  (l2_resp_valid),
      .l2_resp_data_o   (l2_resp_data),
      .mem_req_valid_o  (mem_req_valid),
      .mem_req_ready_i  (mem_req_ready),
      .mem_req_addr_o   (mem_req_addr),
      .mem_req_rw_o     (mem_req_rw),
      .mem_req_data_o   (mem_req_data),
      .mem_resp_valid_i (mem_resp_valid),
      .mem_resp_data_i  (mem_resp_data),
      .dbg_state_o      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic line_t mem_data(input laddr_t a);
      line_t r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = {6'(i), a};
      return r;
   endfunction

   function automatic mreq_t mk(input logic rw, input laddr_t a, input line_t d);
      mreq_t m;
      m.rw = rw; m.addr = a; m.data = d;
      return m;
   endfunction

   // ---------------- memory model / memory scoreboard ----------------
   initial begin
      int    cnt;
      line_t pend;
      mreq_t e;
      cnt = 0;
      pend = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (!reset_n) begin
            cnt = 0;
            mem_resp_valid = 1'b0;
            mem_resp_data = '0;
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data = '0;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data = pend;
                  mresp_cyc = cyc;
               end
            end
            if (!mem_req_valid && (mem_req_rw !== 1'b0 || mem_req_addr !== '0 || mem_req_data !== '0))
               mem_idle_err++;
            if (mem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
            if (mem_req_valid && mem_req_ready) begin
               n_checks++;
               if (exp_mem_q.size() == 0) begin
                  $display("FAIL mem_unexpected: got rw=%0b addr=%h, expected no memory request",
                           mem_req_rw, mem_req_addr);
               end else begin
                  e = exp_mem_q.pop_front();
                  if (mem_req_rw !== e.rw || mem_req_addr !== e.addr || (e.rw && mem_req_data !== e.data))
                     $display("FAIL mem_req: got rw=%0b addr=%h data=%h, want rw=%0b addr=%h data=%h",
                              mem_req_rw, mem_req_addr, mem_req_data, e.rw, e.addr, e.data);
                  else
                     n_pass++;
               end
               if (mem_req_rw) begin
                  mem_store[mem_req_addr] = mem_req_data;
               end else begin
                  cnt = 3;
                  pend = mem_store.exists(mem_req_addr) ? mem_store[mem_req_addr] : mem_data(mem_req_addr);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input laddr_t a, input logic rw, input line_t d);
      int t = 0;
      while (!l2_req_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!l2_req_ready) begin
         n_checks++;
         $display("FAIL issue_ready: got ready=0 for 50 cycles, want 1");
      end
      l2_req_valid = 1'b1;
      l2_req_addr  = a;
      l2_req_rw    = rw;
      l2_req_data  = d;
      hs_cyc = cyc;
      first_req_cyc = -1;
      mresp_cyc = -1;
      @(posedge clk); #1;
      l2_req_valid = 1'b0;
      l2_req_addr  = '0;
      l2_req_rw    = 1'b0;
      l2_req_data  = '0;
   endtask

   // Collects response pulses until the cache is ready again (cycle counts relative to the handshake).
   task automatic wait_done(output int resp_rel, output int resp_n, output line_t rdata, output int done_rel);
      resp_rel = -1; resp_n = 0; rdata = '0; done_rel = -1;
      for (int t = 0; t < 200; t++) begin
         if (l2_resp_valid) begin
            resp_n++;
            resp_rel = cyc - hs_cyc;
            rdata = l2_resp_data;
         end else if (l2_resp_data !== '0) begin
            resp_idle_err++;
         end
         if (l2_req_ready) begin
            done_rel = cyc - hs_cyc;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (l2_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", l2_req_ready); else n_pass++;
      n_checks++; if (l2_resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", l2_resp_valid); else n_pass++;
      n_checks++; if (l2_resp_data !== '0) $display("FAIL reset_resp_data: got %h want 0", l2_resp_data); else n_pass++;
      n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); else n_pass++;
      n_checks++; if (mem_req_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_req_addr); else n_pass++;
      n_checks++; if (mem_req_rw !== 1'b0) $display("FAIL reset_mem_rw: got %b want 0", mem_req_rw); else n_pass++;
      n_checks++; if (mem_req_data !== '0) $display("FAIL reset_mem_data: got %h want 0", mem_req_data); else n_pass++;
   endtask

   task automatic test_read_miss();
      int rr, rn, dr; line_t rd;
      exp_mem_q.push_back(mk(1'b0, 26'h010, '0));
      exp_q.push_back(mem_data(26'h010));
      issue(26'h010, 1'b0, '0);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rn !== 1) $display("FAIL miss_pulses: got %0d want 1", rn); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL miss_data: got %h", rd); else n_pass++;
      n_checks++; if (first_req_cyc - hs_cyc !== 2) $display("FAIL miss_req_cycle: got %0d want 2", first_req_cyc - hs_cyc); else n_pass++;
      n_checks++; if (rr !== mresp_cyc - hs_cyc + 1) $display("FAIL miss_resp_cycle: got %0d want %0d", rr, mresp_cyc - hs_cyc + 1); else n_pass++;
      n_checks++; if (dr !== 7) $display("FAIL miss_ready_cycle: got %0d want 7", dr); else n_pass++;
      n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL miss_mem_pending: got %0d want 0", exp_mem_q.size()); else n_pass++;
   endtask

   task automatic test_read_hit();
      int rr, rn, dr; line_t rd;
      exp_q.push_back(mem_data(26'h010));
      issue(26'h010, 1'b0, '0);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rr !== 1 || rn !== 1) $display("FAIL hit_resp: got cycle %0d pulses %0d want 1/1", rr, rn); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL hit_data: got %h", rd); else n_pass++;
      n_checks++; if (dr !== 2) $display("FAIL hit_ready_cycle: got %0d want 2", dr); else n_pass++;
      n_checks++; if (first_req_cyc !== -1) $display("FAIL hit_mem_quiet: got request at %0d want none", first_req_cyc); else n_pass++;
   endtask

   task automatic test_write_hit();
      int rr, rn, dr; line_t rd;
      issue(26'h010, 1'b1, LINE_A5);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rn !== 0 || dr !== 2) $display("FAIL whit_done: got pulses %0d ready %0d want 0/2", rn, dr); else n_pass++;
      exp_q.push_back(LINE_A5);
      issue(26'h010, 1'b0, '0);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rr !== 1 || rn !== 1) $display("FAIL whit_read_resp: got cycle %0d pulses %0d want 1/1", rr, rn); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL whit_read_data: got %h want %h", rd, LINE_A5); else n_pass++;
      n_checks++; if (first_req_cyc !== -1) $display("FAIL whit_mem_quiet: got request at %0d want none", first_req_cyc); else n_pass++;
   endtask

   task automatic test_dirty_evict();
      int rr, rn, dr; line_t rd;
      exp_mem_q.push_back(mk(1'b1, 26'h010, LINE_A5));
      exp_mem_q.push_back(mk(1'b0, 26'h110, '0));
      exp_q.push_back(mem_data(26'h110));
      issue(26'h110, 1'b0, '0);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rn !== 1) $display("FAIL evict_pulses: got %0d want 1", rn); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL evict_data: got %h", rd); else n_pass++;
      n_checks++; if (dr !== 8) $display("FAIL evict_ready_cycle: got %0d want 8", dr); else n_pass++;
      n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL evict_mem_pending: got %0d want 0", exp_mem_q.size()); else n_pass++;
   endtask

   task automatic test_write_miss_bp();
      int rr, rn, dr, t, unstable; line_t rd;
      mem_req_ready = 1'b0;
      issue(26'h220, 1'b1, LINE_DB);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rn !== 0 || dr !== 2) $display("FAIL wmiss_done: got pulses %0d ready %0d want 0/2", rn, dr); else n_pass++;
      n_checks++; if (first_req_cyc !== -1) $display("FAIL wmiss_mem_quiet: got request at %0d want none", first_req_cyc); else n_pass++;
      exp_mem_q.push_back(mk(1'b1, 26'h220, LINE_DB));
      exp_mem_q.push_back(mk(1'b0, 26'h320, '0));
      exp_q.push_back(mem_data(26'h320));
      issue(26'h320, 1'b0, '0);
      t = 0;
      while (!mem_req_valid && t < 20) begin
         @(posedge clk); #1; t++;
      end
      n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL stall_wb_seen: got valid=%b want 1", mem_req_valid); else n_pass++;
      unstable = 0;
      repeat (6) begin
         if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 26'h220 || mem_req_data !== LINE_DB)
            unstable++;
         @(posedge clk); #1;
      end
      n_checks++; if (unstable !== 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
      n_checks++; if (first_req_cyc - hs_cyc !== 2) $display("FAIL stall_req_cycle: got %0d want 2", first_req_cyc - hs_cyc); else n_pass++;
      mem_req_ready = 1'b1;
      wait_done(rr, rn, rd, dr);
      n_checks++; if (rn !== 1) $display("FAIL stall_pulses: got %0d want 1", rn); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL stall_data: got %h", rd); else n_pass++;
      n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL stall_mem_pending: got %0d want 0", exp_mem_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      int rr, rn, dr, t; line_t rd;
      exp_mem_q.push_back(mk(1'b0, 26'h030, '0));
      issue(26'h030, 1'b0, '0);
      t = 0;
      while (!(mem_req_valid && !mem_req_rw) && t < 20) begin
         @(posedge clk); #1; t++;
      end
      @(posedge clk); #1;
      n_checks++; if (dbg_state !== 3'd4) $display("FAIL rst_in_fill_wait: got state %0d want 4", dbg_state); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++; if (l2_req_ready !== 1'b1 || l2_resp_valid !== 1'b0 || l2_resp_data !== '0)
         $display("FAIL rst_bus_outputs: got ready=%b resp_valid=%b want 1/0", l2_req_ready, l2_resp_valid); else n_pass++;
      n_checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_rw !== 1'b0 || mem_req_data !== '0)
         $display("FAIL rst_mem_outputs: got valid=%b addr=%h rw=%b want 0/0/0", mem_req_valid, mem_req_addr, mem_req_rw); else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL rst_fill_accepted: got %0d pending want 0", exp_mem_q.size()); else n_pass++;
      // 0x010 was invalidated; memory holds the A5 line written back earlier.
      exp_mem_q.push_back(mk(1'b0, 26'h010, '0));
      exp_q.push_back(LINE_A5);
      issue(26'h010, 1'b0, '0);
      wait_done(rr, rn, rd, dr);
      n_checks++; if (first_req_cyc - hs_cyc !== 2) $display("FAIL rst_miss_req_cycle: got %0d want 2", first_req_cyc - hs_cyc); else n_pass++;
      n_checks++; if (rn !== 1 || dr !== 7) $display("FAIL rst_miss_done: got pulses %0d ready %0d want 1/7", rn, dr); else n_pass++;
      n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL rst_miss_data: got %h want %h", rd, LINE_A5); else n_pass++;
      n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL rst_miss_mem_pending: got %0d want 0", exp_mem_q.size()); else n_pass++;
   endtask

   // Random back-to-back traffic on indices 0x40..0x43 against a shadow cache.
   task automatic test_back_to_back();
      logic   sv[4], sd[4];
      int     st[4];
      line_t  sdat[4];
      line_t  shm [laddr_t];
      int     rr, rn, dr, i, tg;
      logic   rw, hit;
      laddr_t a, victim;
      line_t  d, f, rd;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         sv[k] = 1'b0; sd[k] = 1'b0; st[k] = 0; sdat[k] = '0;
      end
      for (int op = 0; op < 16; op++) begin
         i  = $urandom_range(0, 3);
         tg = $urandom_range(0, 3);
         rw = 1'($urandom_range(0, 1));
         for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
         a = laddr_t'(tg * 256 + 'h40 + i);
         hit = sv[i] && st[i] == tg;
         if (!hit && sv[i] && sd[i]) begin
            victim = laddr_t'(st[i] * 256 + 'h40 + i);
            exp_mem_q.push_back(mk(1'b1, victim, sdat[i]));
            shm[victim] = sdat[i];
         end
         if (rw) begin
            sv[i] = 1'b1; sd[i] = 1'b1; st[i] = tg; sdat[i] = d;
         end else if (hit) begin
            exp_q.push_back(sdat[i]);
         end else begin
            exp_mem_q.push_back(mk(1'b0, a, '0));
            f = shm.exists(a) ? shm[a] : mem_data(a);
            sv[i] = 1'b1; sd[i] = 1'b0; st[i] = tg; sdat[i] = f;
            exp_q.push_back(f);
         end
         issue(a, rw, rw ? d : '0);
         wait_done(rr, rn, rd, dr);
         n_checks++; if (dr < 0) $display("FAIL b2b_timeout: op %0d got no ready within 200 cycles", op); else n_pass++;
         n_checks++; if (rn !== (rw ? 0 : 1)) $display("FAIL b2b_pulses: op %0d got %0d want %0d", op, rn, rw ? 0 : 1); else n_pass++;
         if (!rw) begin
            n_checks++; if (rd !== exp_q.pop_front()) $display("FAIL b2b_data: op %0d addr %h got %h", op, a, rd); else n_pass++;
         end
         n_checks++; if (exp_mem_q.size() !== 0) $display("FAIL b2b_mem_pending: op %0d got %0d want 0", op, exp_mem_q.size()); else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_dirty_evict();
      test_write_miss_bp();
      test_reset_mid_fill();
      test_back_to_back();
      repeat (2) @(posedge clk); #1;
      n_checks++; if (mem_idle_err !== 0) $display("FAIL mem_idle_fields: got %0d nonzero idle cycles want 0", mem_idle_err); else n_pass++;
      n_checks++; if (resp_idle_err !== 0) $display("FAIL resp_idle_data: got %0d nonzero idle cycles want 0", resp_idle_err); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
